// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4-Lite read arbiter.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    ERR   = 3'd3,
    DRAIN = 3'd4
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Grant index: instruction fetch unit is master 0, load/store unit master 1
  localparam logic IFU = 1'b0;
  localparam logic LSU = 1'b1;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI4-Lite read channel (AR + R) bundle with master and slave views.
interface axi_read_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rready;

  // Side that issues reads
  modport master (
    output araddr, arvalid, rready,
    input  arready, rvalid, rdata, rresp
  );

  // Side that serves reads
  modport slave (
    input  araddr, arvalid, rready,
    output arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/arb_watchdog.sv
// Saturating cycle counter used as the arbiter's response watchdog.
module arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; otherwise count while enabled and stick at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter letting IFU (m0) and LSU (m1) share one AXI4-Lite
// read slave, one outstanding read at a time, with a stall watchdog that
// answers SLVERR when the slave stops responding.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  axi_read_arbiter_if.slave  m0,
  axi_read_arbiter_if.slave  m1,
  axi_read_arbiter_if.master s
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_grant_q, last_grant_d;
  logic       from_data_q, from_data_d;
  logic       timer_expired;

  // Signals of whichever master currently holds the grant
  logic [ADDR_W-1:0] g_araddr;
  logic              g_arvalid;
  logic              g_rready;
  logic              g_arready;
  logic              g_rvalid;
  logic [DATA_W-1:0] g_rdata;
  logic [1:0]        g_rresp;

  assign g_araddr  = (grant_q == LSU) ? m1.araddr  : m0.araddr;
  assign g_arvalid = (grant_q == LSU) ? m1.arvalid : m0.arvalid;
  assign g_rready  = (grant_q == LSU) ? m1.rready  : m0.rready;

  // Timer restarts on every state change and only runs while waiting on the slave
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_d != state_q),
    .en_i      ((state_q == ADDR) || (state_q == DATA) || (state_q == DRAIN)),
    .expired_o (timer_expired)
  );

  // State, grant and round-robin history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= IFU;
      last_grant_q <= LSU;
      from_data_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      from_data_q  <= from_data_d;
    end
  end

  // Next-state, arbitration and error-origin tracking
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    from_data_d  = from_data_q;
    case (state_q)
      IDLE: begin
        if (m0.arvalid || m1.arvalid) begin
          state_d = ADDR;
          if (m0.arvalid && m1.arvalid) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = m0.arvalid ? IFU : LSU;
          end
        end
      end
      ADDR: begin
        if (g_arvalid && s.arready) begin
          state_d = DATA;
        end else if (timer_expired) begin
          state_d     = ERR;
          from_data_d = 1'b0;
        end
      end
      DATA: begin
        if (s.rvalid && g_rready) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end else if (timer_expired && !s.rvalid) begin
          state_d     = ERR;
          from_data_d = 1'b1;
        end
      end
      ERR: begin
        // A slave that accepted the address may still answer; absorb it in DRAIN
        if (g_rready) begin
          last_grant_d = grant_q;
          state_d      = from_data_q ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (s.rvalid || timer_expired) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output steering: slave channel to the granted master, everything else quiet
  always_comb begin
    s.araddr   = '0;
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    g_arready  = 1'b0;
    g_rvalid   = 1'b0;
    g_rdata    = '0;
    g_rresp    = RESP_OKAY;
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rdata   = '0;
    m0.rresp   = RESP_OKAY;
    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.rdata   = '0;
    m1.rresp   = RESP_OKAY;
    case (state_q)
      ADDR: begin
        s.araddr  = g_araddr;
        s.arvalid = g_arvalid;
        g_arready = s.arready;
      end
      DATA: begin
        g_rvalid = s.rvalid;
        g_rdata  = s.rdata;
        g_rresp  = s.rresp;
        s.rready = g_rready;
      end
      ERR: begin
        g_rvalid = 1'b1;
        g_rresp  = RESP_SLVERR;
      end
      DRAIN: begin
        s.rready = 1'b1;
      end
      default: begin
      end
    endcase
    if (grant_q == LSU) begin
      m1.arready = g_arready;
      m1.rvalid  = g_rvalid;
      m1.rdata   = g_rdata;
      m1.rresp   = g_rresp;
    end else begin
      m0.arready = g_arready;
      m0.rvalid  = g_rvalid;
      m0.rdata   = g_rdata;
      m0.rresp   = g_rresp;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
`timescale 1ns/1ps
module tb_axi_read_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  axi_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  axi_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

  axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  typedef struct {
    int          m;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   lg_model = 1;   // predicted last_grant
  int   slv_r_wait = 0; // slave cycles between AR handshake and rvalid

  function automatic logic [31:0] slv_data(input logic [31:0] a);
    return a + 32'h0000_0400;
  endfunction

  task automatic push_exp(input int m, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.m = m; e.data = d; e.resp = r;
    sb_q.push_back(e);
  endtask

  // Slave model: arready driven by the tests, R response after slv_r_wait cycles
  initial begin : slave_model
    logic        ar_hs, r_hs, rst_s, busy;
    logic [31:0] a, addr_l;
    int          r_cnt;
    busy = 1'b0; r_cnt = 0; addr_l = '0;
    s_if.rvalid = 1'b0; s_if.rdata = '0; s_if.rresp = 2'b00;
    forever begin
      @(negedge clk);
      ar_hs = s_if.arvalid && s_if.arready;
      r_hs  = s_if.rvalid && s_if.rready;
      a     = s_if.araddr;
      rst_s = rst;
      @(posedge clk); #1;
      if (rst_s) begin
        busy = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0;
      end else begin
        if (r_hs) begin
          busy = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0;
        end
        if (ar_hs) begin
          busy = 1'b1; r_cnt = 0; addr_l = a;
        end
        if (busy && !s_if.rvalid) begin
          if (r_cnt >= slv_r_wait) begin
            s_if.rvalid = 1'b1; s_if.rdata = slv_data(addr_l); s_if.rresp = 2'b00;
          end else begin
            r_cnt++;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every master R handshake pops and compares one entry
  logic        mon_v, mon_r;
  logic [31:0] mon_d;
  logic [1:0]  mon_rs;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (m0_if.rvalid && m1_if.rvalid) begin
        failures++;
        $display("FAIL rvalid_exclusive: m0.rvalid=1 m1.rvalid=1, required at most one");
      end
      for (int i = 0; i < 2; i++) begin
        mon_v  = (i == 0) ? m0_if.rvalid : m1_if.rvalid;
        mon_r  = (i == 0) ? m0_if.rready : m1_if.rready;
        mon_d  = (i == 0) ? m0_if.rdata  : m1_if.rdata;
        mon_rs = (i == 0) ? m0_if.rresp  : m1_if.rresp;
        if (mon_v && mon_r) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: m%0d beat data=%h resp=%b, required no beat", i, mon_d, mon_rs);
          end else begin
            mon_e = sb_q.pop_front();
            if (mon_e.m != i || mon_d !== mon_e.data || mon_rs !== mon_e.resp) begin
              failures++;
              $display("FAIL sb_beat: got m%0d data=%h resp=%b, required m%0d data=%h resp=%b",
                       i, mon_d, mon_rs, mon_e.m, mon_e.data, mon_e.resp);
            end else begin
              $display("beat m%0d data=%h resp=%b ok", i, mon_d, mon_rs);
            end
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    m0_if.arvalid = 1'b0; m1_if.arvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lg_model = 1;
  endtask

  // Issue one read from master m; returns once the AR (or an error R) is seen
  task automatic do_read(input int m, input logic [31:0] addr);
    bit done = 1'b0;
    @(posedge clk); #1;
    if (m == 0) begin m0_if.araddr = addr; m0_if.arvalid = 1'b1; end
    else        begin m1_if.araddr = addr; m1_if.arvalid = 1'b1; end
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (m == 0) done = (m0_if.arvalid && m0_if.arready) || m0_if.rvalid;
      else        done = (m1_if.arvalid && m1_if.arready) || m1_if.rvalid;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL ar_wait: m%0d handshake seen=0, required 1 within 100 cycles", m);
    end
    @(posedge clk); #1;
    if (m == 0) begin m0_if.arvalid = 1'b0; m0_if.araddr = '0; end
    else        begin m1_if.arvalid = 1'b0; m1_if.araddr = '0; end
  endtask

  task automatic wait_sb(input string name);
    int c = 0;
    while (sb_q.size() != 0 && c < 300) begin
      @(negedge clk); c++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s: scoreboard holds %0d entries, required 0", name, sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({m0_if.arready, m0_if.rvalid, m1_if.arready, m1_if.rvalid, s_if.arvalid, s_if.rready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_valids: got %b, required 000000",
               {m0_if.arready, m0_if.rvalid, m1_if.arready, m1_if.rvalid, s_if.arvalid, s_if.rready});
    end
    checks++;
    if (m0_if.rdata !== 32'h0 || m1_if.rdata !== 32'h0 || s_if.araddr !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: m0=%h m1=%h s_araddr=%h, required all 0", m0_if.rdata, m1_if.rdata, s_if.araddr);
    end
    checks++;
    if (m0_if.rresp !== 2'b00 || m1_if.rresp !== 2'b00) begin
      failures++;
      $display("FAIL reset_resp: m0=%b m1=%b, required 00", m0_if.rresp, m1_if.rresp);
    end
  endtask

  task automatic test_single_ifu();
    s_if.arready = 1'b1; slv_r_wait = 0;
    push_exp(0, 32'h0000_0413, 2'b00); lg_model = 0;
    @(posedge clk); #1;
    m0_if.araddr = 32'h13; m0_if.arvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({m1_if.arready, m1_if.rvalid, m1_if.rdata, m1_if.rresp} !== 36'h0) begin
        failures++;
        $display("FAIL single_m1_quiet: cycle %0d m1 outputs=%h, required 0", c,
                 {m1_if.arready, m1_if.rvalid, m1_if.rdata, m1_if.rresp});
      end
      checks++;
      case (c)
        0: if (s_if.arvalid !== 1'b0) begin
             failures++; $display("FAIL single_arb_cycle: s_arvalid=%b, required 0", s_if.arvalid);
           end
        1: if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h13 || m0_if.arready !== 1'b1) begin
             failures++;
             $display("FAIL single_ar: s_arvalid=%b s_araddr=%h m0_arready=%b, required 1 00000013 1",
                      s_if.arvalid, s_if.araddr, m0_if.arready);
           end
        2: if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'h413 || m0_if.rresp !== 2'b00) begin
             failures++;
             $display("FAIL single_r: rvalid=%b rdata=%h rresp=%b, required 1 00000413 00",
                      m0_if.rvalid, m0_if.rdata, m0_if.rresp);
           end
        default: if (m0_if.rvalid !== 1'b0) begin
             failures++; $display("FAIL single_done: m0_rvalid=%b, required 0", m0_if.rvalid);
           end
      endcase
      @(posedge clk); #1;
      if (c == 1) begin m0_if.arvalid = 1'b0; m0_if.araddr = '0; end
    end
    wait_sb("single_sb");
  endtask

  task automatic test_tie();
    int w;
    apply_reset();
    s_if.arready = 1'b1; slv_r_wait = 1;
    // pair right after reset
    w = 1 - lg_model;
    push_exp(w, slv_data(w == 0 ? 32'h100 : 32'h200), 2'b00);
    push_exp(1 - w, slv_data(w == 0 ? 32'h200 : 32'h100), 2'b00);
    lg_model = 1 - w;
    fork
      do_read(0, 32'h100);
      do_read(1, 32'h200);
    join
    wait_sb("tie1_sb");
    // lone IFU read moves last_grant to IFU
    push_exp(0, slv_data(32'h300), 2'b00); lg_model = 0;
    do_read(0, 32'h300);
    wait_sb("tie_single_sb");
    // second pair
    w = 1 - lg_model;
    push_exp(w, slv_data(w == 0 ? 32'h110 : 32'h210), 2'b00);
    push_exp(1 - w, slv_data(w == 0 ? 32'h210 : 32'h110), 2'b00);
    lg_model = 1 - w;
    fork
      do_read(0, 32'h110);
      do_read(1, 32'h210);
    join
    wait_sb("tie2_sb");
  endtask

  task automatic test_rready_stall();
    int c = 0;
    s_if.arready = 1'b1; slv_r_wait = 0;
    m1_if.rready = 1'b0;
    push_exp(1, slv_data(32'h44), 2'b00); lg_model = 1;
    do_read(1, 32'h44);
    do begin @(negedge clk); c++; end while (!m1_if.rvalid && c < 50);
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (m1_if.rvalid !== 1'b1 || m1_if.rdata !== slv_data(32'h44) || s_if.rready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold: k=%0d rvalid=%b rdata=%h s_rready=%b, required 1 %h 0",
                 k, m1_if.rvalid, m1_if.rdata, s_if.rready, slv_data(32'h44));
      end
      @(posedge clk); #1;
    end
    m1_if.rready = 1'b1;
    wait_sb("stall_sb");
  endtask

  task automatic test_ar_timeout();
    int c = 0;
    bit seen = 1'b0;
    s_if.arready = 1'b0;
    push_exp(0, 32'h0, 2'b10); lg_model = 0;
    @(posedge clk); #1;
    m0_if.araddr = 32'h80; m0_if.arvalid = 1'b1;
    while (!seen && c < 100) begin
      @(negedge clk);
      if (m0_if.rvalid) seen = 1'b1; else c++;
    end
    checks++;
    if (c != TIMEOUT + 2) begin
      failures++;
      $display("FAIL ar_timeout_latency: error rvalid in cycle %0d, required %0d", c, TIMEOUT + 2);
    end
    checks++;
    if (s_if.arvalid !== 1'b0 || s_if.rready !== 1'b0) begin
      failures++;
      $display("FAIL ar_timeout_err: s_arvalid=%b s_rready=%b, required 0 0", s_if.arvalid, s_if.rready);
    end
    @(posedge clk); #1;
    m0_if.arvalid = 1'b0; m0_if.araddr = '0;
    @(negedge clk);
    checks++;
    if (s_if.rready !== 1'b0 || m0_if.rvalid !== 1'b0) begin
      failures++;
      $display("FAIL ar_timeout_no_drain: s_rready=%b m0_rvalid=%b, required 0 0", s_if.rready, m0_if.rvalid);
    end
    wait_sb("ar_timeout_sb");
    s_if.arready = 1'b1;
  endtask

  task automatic test_late_resp();
    int c = 0;
    s_if.arready = 1'b1; slv_r_wait = 20;
    push_exp(0, 32'h0, 2'b10); lg_model = 0;
    do_read(0, 32'h90);
    while (!m0_if.rvalid && c < 60) begin @(negedge clk); c++; end
    checks++;
    if (m0_if.rresp !== 2'b10) begin
      failures++;
      $display("FAIL late_err: m0_rresp=%b, required 10", m0_if.rresp);
    end
    @(posedge clk); #1;
    c = 0;
    do begin
      @(negedge clk);
      checks++;
      if (s_if.rready !== 1'b1 || m0_if.rvalid !== 1'b0) begin
        failures++;
        $display("FAIL late_drain: s_rready=%b m0_rvalid=%b, required 1 0", s_if.rready, m0_if.rvalid);
      end
      c++;
    end while (!s_if.rvalid && c < 40);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (s_if.rready !== 1'b0) begin
      failures++;
      $display("FAIL late_drain_exit: s_rready=%b, required 0", s_if.rready);
    end
    wait_sb("late_err_sb");
    slv_r_wait = 0;
    push_exp(1, slv_data(32'hA0), 2'b00); lg_model = 1;
    do_read(1, 32'hA0);
    wait_sb("late_next_sb");
  endtask

  task automatic test_reset_in_data();
    int w;
    s_if.arready = 1'b1; slv_r_wait = 0;
    push_exp(0, slv_data(32'h10), 2'b00); lg_model = 0;
    do_read(0, 32'h10);
    wait_sb("rst_pre_sb");
    slv_r_wait = 6;
    do_read(1, 32'h20);
    @(negedge clk);
    checks++;
    if (s_if.rready !== 1'b1) begin
      failures++;
      $display("FAIL rst_in_data_pre: s_rready=%b, required 1", s_if.rready);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    lg_model = 1;
    @(negedge clk);
    checks++;
    if ({m0_if.arready, m0_if.rvalid, m1_if.arready, m1_if.rvalid, s_if.arvalid, s_if.rready} !== 6'b0 ||
        m1_if.rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_in_data_outputs: valids=%b m1_rdata=%h, required 000000 0",
               {m0_if.arready, m0_if.rvalid, m1_if.arready, m1_if.rvalid, s_if.arvalid, s_if.rready},
               m1_if.rdata);
    end
    slv_r_wait = 0;
    w = 1 - lg_model;
    push_exp(w, slv_data(w == 0 ? 32'h30 : 32'h40), 2'b00);
    push_exp(1 - w, slv_data(w == 0 ? 32'h40 : 32'h30), 2'b00);
    lg_model = 1 - w;
    fork
      do_read(0, 32'h30);
      do_read(1, 32'h40);
    join
    wait_sb("rst_tie_sb");
  endtask

  initial begin
    m0_if.araddr = '0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b1;
    m1_if.araddr = '0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b1;
    s_if.arready = 1'b0;
    test_reset();
    test_single_ifu();
    test_tie();
    test_rready_stall();
    test_ar_timeout();
    test_late_resp();
    test_reset_in_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
